keypad_display_peripheral: RTL
==============================

Name: keypad_display_peripheral

Overview:
Memory-mapped output peripheral that drives a multiplexed common-cathode 7-segment display of DIGITS digits. It is the display counterpart of the keypad input path. The CPU writes 32-bit ASCII codes, using the same character set the keypad produces, into a terminal-style shift buffer. The block continuously scans the digits one at a time, with a blanking interval between digits to prevent ghosting.

Parameters:
DIGITS, 4, number of digits; legal range 1..8.
SCAN_DIV, 16, clock cycles per digit slot; must be > BLANK.
BLANK, 2, cycles at the start of each slot during which all digits are off; must be >= 1.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  single-cycle write strobe from bus decoder
wr_data  input  32  ASCII code; all 32 bits significant
digit_en  output  DIGITS  one-hot digit select, active-high; bit 0 = rightmost digit
seg  output  7  segments {g,f,e,d,c,b,a}, active-high
char_count  output  4  number of occupied buffer positions, 0..DIGITS

Behaviour:
- Reset (async, rst_n low):
  - buffer: all positions blank.
  - scan counter cnt = 0, digit index idx = 0.
  - digit_en = 0, seg = 0, char_count = 0.
  - All of these take effect immediately, regardless of clock or scan phase.
- Buffer: DIGITS entries, each stored as a 7-bit segment pattern. Entry 0 is the rightmost digit.
- Write decode (on a clk edge with wr_en = 1), compared on the full 32-bit wr_data:
  - Printable set, mapped to segment patterns:
    - 48..57 ('0'-'9') -> 3F,06,5B,4F,66,6D,7D,07,7F,6F
    - 65..70 ('A'-'F') -> 77,7C,39,5E,79,71
    - 42 '*' -> 63; 35 '#' -> 76; 45 '-' -> 40; 32 ' ' -> 00
  - Printable write: entry[i] <= entry[i-1] for i = DIGITS-1..1; entry[0] <= pattern; char_count <= min(char_count+1, DIGITS). The leftmost entry is discarded once full.
  - 8 (backspace):
    - If char_count > 0: entry[i] <= entry[i+1] for i = 0..DIGITS-2; entry[DIGITS-1] <= blank; char_count decrements.
    - If char_count = 0: no change.
  - 12 (form feed): all entries blank, char_count = 0.
  - Any other value, including any value with bits [31:8] nonzero: ignored, no state change.
  - wr_en = 0: no buffer change.
  - Writes are accepted every cycle with no back-pressure; back-to-back writes each take effect.
- Scan:
  - cnt increments every cycle.
  - At cnt = SCAN_DIV-1: cnt <= 0 and idx <= (idx = DIGITS-1) ? 0 : idx+1.
  - Buffer writes and scan advance are independent; they may occur in the same cycle.
- Outputs (registered), computed each edge from the pre-edge cnt, idx and buffer:
  - Blank phase (cnt < BLANK): digit_en <= 0, seg <= 0.
  - Active phase: digit_en <= onehot(idx), seg <= entry[idx].
  - Latency: a write at edge E updates the buffer at E and is visible on seg at edge E+1 if that digit's slot is active.
- Each digit is lit for SCAN_DIV-BLANK cycles per frame. Frame period is DIGITS*SCAN_DIV cycles.
- No two digit_en bits are ever high simultaneously. digit_en and seg change only on clk edges, except during async reset.

Test Plan:
- Reset, then run 64 cycles with no writes (DIGITS=4, SCAN_DIV=16, BLANK=2):
  - seg stays 0 and char_count = 0.
  - digit_en shows 0 for 2 cycles, then 0001 for 14 cycles, then repeats with 0010, 0100, 1000.
  - digit_en returns to 0001 at cycle 66.
- Write 49, 50, 51, 52 ('1' '2' '3' '4') -> char_count = 4; seg = 66 while digit_en = 0001, 4F at 0010, 5B at 0100, 06 at 1000.
- Write 53 ('5') on top of the previous state -> display reads 2,3,4,5 (left to right); seg = 6D at 0001, 5B at 1000; char_count stays 4.
- Backspace handling:
  - Write 8 -> display blank,2,3,4; seg = 00 at 1000; char_count = 3.
  - Write 12, then 8 -> all seg 00, char_count = 0.
- Write 90 ('Z') and 0x00000131 -> buffer and char_count unchanged.
- Write exactly at cnt = SCAN_DIV-1 -> the write and the idx advance both occur.
- Assert rst_n low mid-slot while digit_en = 0100 -> digit_en = 0, seg = 0 and char_count = 0 immediately. After release, scanning restarts from idx 0 with an empty buffer.

Source files
------------

// File: rtl/keypad_display_peripheral.sv
// keypad_display_peripheral
//   Memory-mapped driver for a multiplexed common-cathode 7-segment display.
//   The CPU writes ASCII codes into a terminal-style shift buffer. Entry 0 is
//   the rightmost digit. Each digit gets a scan slot of SCAN_DIV cycles. The
//   first BLANK cycles of every slot keep all digits dark, which stops the
//   previous digit's pattern from ghosting onto the next one.
//
// Ports
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   wr_en      : single-cycle write strobe from the bus decoder
//   wr_data    : 32-bit ASCII code; every bit is significant
//   digit_en   : one-hot digit select, active-high, bit 0 = rightmost digit
//   seg        : segments {g,f,e,d,c,b,a}, active-high
//   char_count : number of occupied buffer positions, 0..DIGITS
module keypad_display_peripheral #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 16,
   parameter int BLANK    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [31:0]       wr_data,
   output logic [DIGITS-1:0] digit_en,
   output logic [6:0]        seg,
   output logic [3:0]        char_count
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
   localparam logic [3:0]       COUNT_MAX = 4'(DIGITS);

   typedef enum logic [1:0] {
      OP_NONE,
      OP_PUSH,
      OP_BKSP,
      OP_CLEAR
   } op_e;

   op_e              op;
   logic [6:0]       pattern;

   logic [6:0]       buf_q [DIGITS];
   logic [6:0]       buf_d [DIGITS];
   logic [3:0]       count_q, count_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [DIGITS-1:0] digit_en_q, digit_en_d;
   logic [6:0]       seg_q, seg_d;

   // Decode on the full 32-bit word, so codes with upper bits set fall to default.
   always_comb begin
      op      = OP_NONE;
      pattern = 7'h00;
      if (wr_en) begin
         op = OP_PUSH;
         case (wr_data)
            32'd48:  pattern = 7'h3F;
            32'd49:  pattern = 7'h06;
            32'd50:  pattern = 7'h5B;
            32'd51:  pattern = 7'h4F;
            32'd52:  pattern = 7'h66;
            32'd53:  pattern = 7'h6D;
            32'd54:  pattern = 7'h7D;
            32'd55:  pattern = 7'h07;
            32'd56:  pattern = 7'h7F;
            32'd57:  pattern = 7'h6F;
            32'd65:  pattern = 7'h77;
            32'd66:  pattern = 7'h7C;
            32'd67:  pattern = 7'h39;
            32'd68:  pattern = 7'h5E;
            32'd69:  pattern = 7'h79;
            32'd70:  pattern = 7'h71;
            32'd42:  pattern = 7'h63;
            32'd35:  pattern = 7'h76;
            32'd45:  pattern = 7'h40;
            32'd32:  pattern = 7'h00;
            32'd8:   op = OP_BKSP;
            32'd12:  op = OP_CLEAR;
            default: op = OP_NONE;
         endcase
      end
   end

   // Buffer next state: push shifts left, backspace shifts right.
   always_comb begin
      for (int i = 0; i < DIGITS; i++) buf_d[i] = buf_q[i];
      count_d = count_q;
      case (op)
         OP_PUSH: begin
            for (int i = DIGITS - 1; i > 0; i--) buf_d[i] = buf_q[i-1];
            buf_d[0] = pattern;
            if (count_q < COUNT_MAX) count_d = count_q + 4'd1;
         end
         OP_BKSP: begin
            if (count_q != 4'd0) begin
               for (int i = 0; i < DIGITS - 1; i++) buf_d[i] = buf_q[i+1];
               buf_d[DIGITS-1] = 7'h00;
               count_d = count_q - 4'd1;
            end
         end
         OP_CLEAR: begin
            for (int i = 0; i < DIGITS; i++) buf_d[i] = 7'h00;
            count_d = 4'd0;
         end
         default: ;
      endcase
   end

   // Scan sequencing and registered outputs, all from pre-edge state.
   always_comb begin
      cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      idx_d      = idx_q;
      digit_en_d = '0;
      seg_d      = 7'h00;
      if (cnt_q == CNT_LAST) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      if (cnt_q >= BLANK_END) begin
         digit_en_d = DIGITS'(1) << idx_q;
         seg_d      = buf_q[idx_q];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DIGITS; i++) buf_q[i] <= 7'h00;
         count_q    <= 4'd0;
         cnt_q      <= '0;
         idx_q      <= '0;
         digit_en_q <= '0;
         seg_q      <= 7'h00;
      end else begin
         for (int i = 0; i < DIGITS; i++) buf_q[i] <= buf_d[i];
         count_q    <= count_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         digit_en_q <= digit_en_d;
         seg_q      <= seg_d;
      end
   end

   assign digit_en   = digit_en_q;
   assign seg        = seg_q;
   assign char_count = count_q;

endmodule
